fifo_rd_ctrl: RTL and testbench

// Read-side controller for the dual-clock sample FIFO. Runs in the fast read domain.
// - Pops 16-bit samples from the FIFO read port, absorbing the FIFO's registered-read latency.
// - Presents samples to the FIR datapath over a valid/ready handshake, without bubbles.
// - Sits between the FIFO's rd_en/rd_data/empty port and the FIR tap-shift input.

---
 rtl/fifo_rd_ctrl.sv | 127 ++++++++++++
 tb/tb_fifo_rd_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller for the dual-clock sample FIFO: pops, absorbs read latency, feeds the FIR over valid/ready.
// Optional FIFO_RD_STATS_EN adds sample_cnt/stall_cnt counters.
//
// state   | meaning
// S_IDLE  | nothing buffered or in flight, waiting for enable
// S_RUN   | popping the FIFO while there is room for the reply
// S_DRAIN | no new pops; in-flight samples still captured and delivered
// S_FLUSH | buffer cleared, in-flight returns dropped until the pipe empties
module fifo_rd_ctrl #(
  parameter int DATA_W     = 16,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk_rd,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              flush,
  input  logic              empty,
  input  logic [DATA_W-1:0] rd_data,
  output logic              rd_en,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [31:0]       sample_cnt,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int BUF_D = RD_LATENCY + 1;
  localparam int PW    = (BUF_D > 2) ? 2 : 1;
  localparam int CW    = 2;
  localparam int SW    = 3;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FLUSH} state_t;

  state_t                state;
  logic [DATA_W-1:0]     sbuf [BUF_D];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         occ;
  logic [RD_LATENCY-1:0] infl;
  logic [SW-1:0]         infl_cnt;
  logic [SW-1:0]         need;
  logic                  pop_out;
  logic                  cap;
  logic                  flush_act;
  logic                  drop;

  // Buffer depth is 2 or 3, so wrap explicitly rather than relying on overflow.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(BUF_D - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    infl_cnt = '0;
    for (int i = 0; i < RD_LATENCY; i++) infl_cnt = infl_cnt + SW'(infl[i]);
  end

  // Only pop when the reply is guaranteed a free slot, counting data already in flight.
  assign pop_out   = out_valid & out_ready;
  assign need      = SW'(occ) + infl_cnt - SW'(pop_out);
  assign rd_en     = enable & ~empty & ~flush & (state == S_RUN) & (need < SW'(BUF_D));
  assign out_valid = (occ != '0) & (state != S_FLUSH);
  assign out_data  = sbuf[rd_ptr];
  assign busy      = (state != S_IDLE);
  assign flush_act = flush & (state != S_IDLE);
  assign drop      = flush_act | (state == S_FLUSH);
  assign cap       = infl[RD_LATENCY-1] & ~drop;

  always_ff @(posedge clk_rd or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      infl   <= '0;
      occ    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < BUF_D; i++) sbuf[i] <= '0;
    end else begin
      infl <= (infl << 1) | RD_LATENCY'(rd_en);
      if (flush_act) begin
        occ    <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (cap) begin
          sbuf[wr_ptr] <= rd_data;
          wr_ptr       <= ptr_next(wr_ptr);
        end
        if (pop_out) rd_ptr <= ptr_next(rd_ptr);
        occ <= occ + CW'(cap) - CW'(pop_out);
      end
      case (state)
        S_IDLE:  if (enable && !flush) state <= S_RUN;
        S_RUN: begin
          if (flush)        state <= S_FLUSH;
          else if (!enable) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (flush)                          state <= S_FLUSH;
          else if (enable)                    state <= S_RUN;
          else if (infl == '0 && occ == '0)   state <= S_IDLE;
        end
        S_FLUSH: if (infl == '0) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef FIFO_RD_STATS_EN
  always_ff @(posedge clk_rd or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt <= '0;
      stall_cnt  <= '0;
    end else if (flush_act) begin
      sample_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      if (pop_out && sample_cnt != '1) sample_cnt <= sample_cnt + 1'b1;
      if (state == S_RUN && empty && occ == '0 && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: FIFO model plus a queue-based reference checked every cycle, and directed literal checks.
module tb_fifo_rd_ctrl;
`ifdef FIFO_RD_STATS_EN
  localparam int RD_LAT = 2;
`else
  localparam int RD_LAT = 1;
`endif
  localparam int BUF_D   = RD_LAT + 1;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DRAIN = 2;
  localparam int M_FLUSH = 3;

  logic        clk_rd = 1'b0;
  logic        rst_n, enable, flush, out_ready;
  logic        empty, rd_en, out_valid, busy;
  logic [15:0] rd_data, out_data;
`ifdef FIFO_RD_STATS_EN
  logic [31:0] sample_cnt;
  logic [15:0] stall_cnt;
`endif

  always #5 clk_rd = ~clk_rd;

  int vectors = 0;
  int miscompares = 0;

  // FIFO with registered read of RD_LAT cycles
  int          mem [256];
  int          fhead = 0;
  int          ftail = 0;
  logic [15:0] d1 = '0;
  logic [15:0] d2 = '0;
  assign empty   = (fhead == ftail);
  assign rd_data = (RD_LAT == 1) ? d1 : d2;
  always @(posedge clk_rd) begin
    if (rd_en) begin
      d1    <= 16'(mem[fhead]);
      fhead <= fhead + 1;
    end
    d2 <= d1;
  end

  fifo_rd_ctrl #(.DATA_W(16), .RD_LATENCY(RD_LAT)) dut (
    .clk_rd(clk_rd), .rst_n(rst_n), .enable(enable), .flush(flush),
    .empty(empty), .rd_data(rd_data), .rd_en(rd_en), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
`ifdef FIFO_RD_STATS_EN
    , .sample_cnt(sample_cnt), .stall_cnt(stall_cnt)
`endif
  );

  task automatic chk(string name, longint act, longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference: buffered samples, in-flight values with cycles remaining, control mode
  int     mbuf[$];
  int     fv[$];
  int     fr[$];
  int     mstate = M_IDLE;
  longint m_samp = 0;
  int     m_stall = 0;
  int     cyc = 0;
  int     rc[$];
  int     dv[$];
  int     dc[$];
  int     rd_empty_cnt = 0;

  always @(negedge clk_rd) begin : cmp
    int n_infl, occ_pre, v;
    bit pop, exp_rd, exp_valid, drop;
    cyc++;
    if (!rst_n) begin
      mbuf.delete(); fv.delete(); fr.delete();
      mstate = M_IDLE; m_samp = 0; m_stall = 0;
      chk("rst_rd_en", rd_en, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_busy", busy, 0);
    end else begin
      n_infl    = fv.size();
      occ_pre   = mbuf.size();
      exp_valid = (occ_pre != 0);
      pop       = exp_valid && out_ready;
      exp_rd    = enable && !empty && !flush && mstate == M_RUN &&
                  (occ_pre + n_infl - int'(pop) < BUF_D);
      chk("rd_en", rd_en, exp_rd);
      chk("out_valid", out_valid, exp_valid);
      chk("busy", busy, mstate != M_IDLE);
      if (exp_valid) chk("out_data", out_data, mbuf[0]);
`ifdef FIFO_RD_STATS_EN
      chk("sample_cnt", sample_cnt, m_samp);
      chk("stall_cnt", stall_cnt, m_stall);
`endif
      if (rd_en) rc.push_back(cyc);
      if (rd_en && empty) rd_empty_cnt++;
      if (out_valid && out_ready) begin
        dv.push_back(out_data);
        dc.push_back(cyc);
      end
      if (flush && mstate != M_IDLE) begin
        m_samp = 0; m_stall = 0;
      end else begin
        if (pop && m_samp != 64'hFFFF_FFFF) m_samp++;
        if (mstate == M_RUN && empty && occ_pre == 0 && m_stall != 16'hFFFF) m_stall++;
      end
      drop = (flush && mstate != M_IDLE) || mstate == M_FLUSH;
      if (pop) void'(mbuf.pop_front());
      while (fr.size() > 0 && fr[0] == 1) begin
        v = fv.pop_front();
        void'(fr.pop_front());
        if (!drop) mbuf.push_back(v);
      end
      foreach (fr[i]) fr[i] = fr[i] - 1;
      if (flush && mstate != M_IDLE) mbuf.delete();
      if (exp_rd) begin
        fv.push_back(mem[fhead] & 16'hFFFF);
        fr.push_back(RD_LAT);
      end
      case (mstate)
        M_IDLE:  if (enable && !flush) mstate = M_RUN;
        M_RUN:   if (flush) mstate = M_FLUSH; else if (!enable) mstate = M_DRAIN;
        M_DRAIN: if (flush) mstate = M_FLUSH; else if (enable) mstate = M_RUN;
                 else if (n_infl == 0 && occ_pre == 0) mstate = M_IDLE;
        default: if (n_infl == 0) mstate = M_IDLE;
      endcase
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk_rd);
      #1;
    end
  endtask

  task automatic push(int v);
    mem[ftail] = v;
    ftail++;
  endtask

  task automatic clear_logs();
    rc.delete(); dv.delete(); dc.delete();
    rd_empty_cnt = 0;
  endtask

  task automatic chk_seq(string name, int first, int n);
    chk({name, "_count"}, dv.size(), n);
    for (int i = 0; i < dv.size() && i < n; i++) chk(name, dv[i], first + i);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; enable = 1'b0; flush = 1'b0; out_ready = 1'b0;
    push(1); push(2); push(3);
    tick(4);
    rst_n = 1'b1;
    tick(1);

    // streaming 1..5
    push(4); push(5);
    clear_logs();
    enable = 1'b1; out_ready = 1'b1;
    tick(12);
    chk("stream_pops", rc.size(), 5);
    if (rc.size() == 5) chk("stream_rd_span", rc[4] - rc[0], 4);
    chk_seq("stream_data", 1, 5);
    if (dc.size() == 5 && rc.size() > 0) begin
      chk("stream_first_lat", dc[0] - rc[0], RD_LAT + 1);
      chk("stream_out_span", dc[4] - dc[0], 4);
    end
    chk("stream_tail_valid", out_valid, 0);

    // backpressure
    out_ready = 1'b0;
    clear_logs();
    for (int v = 1; v <= 5; v++) push(v);
    tick(6);
    chk("bp_pops", rc.size(), BUF_D);
    chk("bp_valid", out_valid, 1);
    chk("bp_head", out_data, 1);
    out_ready = 1'b1;
    tick(10);
    chk_seq("bp_order", 1, 5);

    // slow writer
    clear_logs();
    for (int k = 0; k < 4; k++) begin
      push(80 + k);
      tick(100);
    end
    chk("slow_pops", rc.size(), 4);
    chk("slow_rd_on_empty", rd_empty_cnt, 0);
    chk_seq("slow_order", 80, 4);
    for (int i = 0; i < 4 && i < rc.size() && i < dc.size(); i++)
      chk("slow_lat", dc[i] - rc[i], RD_LAT + 1);

    // drain with one in flight
    clear_logs();
    push(119);
    tick(1);
    enable = 1'b0;
    tick(8);
    chk_seq("drain_deliver", 119, 1);
    chk("drain_busy", busy, 0);

    // flush with two buffered
    clear_logs();
    out_ready = 1'b0;
    push(49); push(50);
    enable = 1'b1;
    tick(6);
    chk("flush_pre_valid", out_valid, 1);
    flush = 1'b1;
    tick(1);
    flush = 1'b0; enable = 1'b0;
    chk("flush_valid_next", out_valid, 0);
    chk("flush_busy", busy, 1);
    tick(3);
    chk("flush_idle_busy", busy, 0);
    chk("flush_no_deliver", dv.size(), 0);
`ifdef FIFO_RD_STATS_EN
    chk("flush_sample_cnt", sample_cnt, 0);
    chk("flush_stall_cnt", stall_cnt, 0);
`endif

    // 10 samples then 4 underrun cycles
    clear_logs();
    for (int i = 0; i < 10; i++) push(200 + i);
    out_ready = 1'b1; enable = 1'b1;
    n = 0;
    while (dv.size() < 10 && n < 60) begin
      tick(1);
      n++;
    end
    chk("stats_wait", dv.size(), 10);
    chk_seq("stats_data", 200, 10);
    tick(3);
    enable = 1'b0;
    tick(1);
`ifdef FIFO_RD_STATS_EN
    chk("stats_sample_cnt", sample_cnt, 10);
    chk("stats_stall_cnt", stall_cnt, 4);
`endif
    tick(1);
    enable = 1'b1;
    tick(1);
    flush = 1'b1;
    tick(1);
    flush = 1'b0; enable = 1'b0;
`ifdef FIFO_RD_STATS_EN
    chk("stats_clr_sample", sample_cnt, 0);
    chk("stats_clr_stall", stall_cnt, 0);
`endif
    tick(2);
    chk("stats_end_busy", busy, 0);

    // reset mid-transfer
    push(300); push(301); push(302);
    enable = 1'b1;
    tick(3);
    rst_n = 1'b0;
    tick(2);
    enable = 1'b0;
    rst_n = 1'b1;
    tick(2);
    chk("post_reset_busy", busy, 0);
    chk("post_reset_valid", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
